vector_alu_sequencer: RTL and testbench
=======================================

# vector_alu_sequencer

Issue controller that executes 128-bit vector ALU operations on one shared 32-bit lane ALU. It processes one lane per cycle and reassembles the four lane results into a 128-bit result. It sits between the decode/execute stage, which uses a valid/ready request port, and the combinational lane ALU, which uses the same 3-bit ALUControl encoding as the vector datapath. Scalar operations (vectorial=0) use lane 0 only.

## Interface
Parameters:
- LANES, 4, number of 32-bit lanes per vector operand
- LANE_W, 32, lane width in bits; operand width is LANES*LANE_W

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  sequencer can accept a request
- in_a  in  128  operand A; lane i = bits [32i+31:32i]
- in_b  in  128  operand B; same lane mapping
- in_alu_control  in  3  operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 sra
- in_vectorial  in  1  1 = all lanes, 0 = scalar (lane 0)
- lane_en  out  1  lane ALU operands are valid this cycle
- lane_a  out  32  lane ALU operand A
- lane_b  out  32  lane ALU operand B
- lane_control  out  3  lane ALU operation (latched in_alu_control)
- lane_result  in  32  combinational lane ALU result for the current lane_a/lane_b/lane_control
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  128  assembled result
- out_zero  out  1  1 when out_result == 0
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: latch a_q, b_q, op_q, vec_q; clear res_q; set lane_idx=0; go to EXEC.
- **EXEC**
  - lane_en=1; lane_a=a_q[lane_idx]; lane_b=b_q[lane_idx]; lane_control=op_q.
  - At each edge, lane_result is written to res_q[lane_idx] and lane_idx increments.
  - After lane LANES-1 is captured, go to DONE.
  - Shift amounts are per lane, taken from b_q[lane_idx][4:0].
  - Scalar (vec_q=0): lanes 1..3 are driven with lane_a=lane_b=0. Their res_q slots are forced to 0 regardless of lane_result.
- **DONE**
  - out_valid=1; out_result=res_q; out_zero=(res_q==0).
  - Hold all outputs stable until out_ready.
  - On out_valid&&out_ready: go to IDLE.
- Outside EXEC: lane_en=0 and lane_a/lane_b/lane_control=0.
- in_ready=0 in EXEC and DONE. in_valid in those states is ignored and not queued.
- lane_idx is a 2-bit counter; it wraps 3 -> 0 only on the transition into DONE.
- Reset values:
  - State: IDLE. in_ready=1 during reset.
  - busy=0, out_valid=0, out_result=0, out_zero=1, lane_en=0, lane_a=0, lane_b=0, lane_control=0.
- Reset asserted mid-operation aborts immediately. The partial result is discarded and is never presented.

## Timing
- Request accepted at edge T.
- Lane k is captured at edge T+1+k.
- DONE is entered at T+4; out_valid is high from T+4.
- Earliest output handshake is edge T+5. in_ready is high again from T+5, so the earliest next accept is T+6 (6-cycle issue interval).
- out_ready held low: DONE persists indefinitely with outputs frozen.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- lane_result must settle within the same cycle as its operands (single-cycle lane ALU).

## Configuration
- **VALU_SCALAR_FAST_EN** defined:
  - A scalar request leaves EXEC after capturing lane 0 and enters DONE at T+1.
  - Upper result slots are 0. Scalar issue interval is 3 cycles.
- **VALU_SCALAR_FAST_EN** undefined:
  - Scalar requests take all four EXEC cycles with zero operands on lanes 1..3, as described above.
  - Scalar latency equals vector latency.

## Test plan
- Scalar add, vectorial=0, A=0x0000000A, B=0x00000014, op 000:
  - out_result=0x...0000001E, out_zero=0.
  - out_valid at T+4 (T+1 with VALU_SCALAR_FAST_EN).
  - lane_a=lane_b=0 on lanes 1..3 when the macro is undefined.
- Vector sub, A={5,6,7,8}, B={1,2,3,4}, op 001:
  - out_result=00000004_00000004_00000004_00000004.
  - lane_a sequence 8,7,6,5 on edges T+1..T+4.
- Vector xor with A=B=0xAAAA…AAAA:
  - out_result=0, out_zero=1.
  - Then vector or of 0x5555…5555 and 0xAAAA…AAAA gives all F's with out_zero=0.
- Backpressure and ignored requests:
  - Hold out_ready=0 for 10 cycles in DONE: out_valid and out_result stay stable, in_ready stays 0.
  - A second in_valid pulse during EXEC/DONE is not accepted.
  - After out_ready, the next request is accepted at T+6.
- Vector sra, A lanes=0x80000000, B lanes=2, op 111:
  - Each lane gives 0xE0000000.
  - Checks the per-lane shift amount taken from b_q.
- Deassert rst_n at lane 2 of a vector add:
  - Outputs go to reset values asynchronously, with no out_valid pulse.
  - After release, a new request completes correctly.

Source files
------------

// File: rtl/vector_alu_sequencer.sv
// Issues 128-bit vector ALU operations one 32-bit lane per cycle on a shared combinational lane ALU.
// Optional macro VALU_SCALAR_FAST_EN: scalar requests complete right after lane 0.
module vector_alu_sequencer #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_a,
  input  logic [LANES*LANE_W-1:0] in_b,
  input  logic [2:0]              in_alu_control,
  input  logic                    in_vectorial,
  output logic                    lane_en,
  output logic [LANE_W-1:0]       lane_a,
  output logic [LANE_W-1:0]       lane_b,
  output logic [2:0]              lane_control,
  input  logic [LANE_W-1:0]       lane_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_result,
  output logic                    out_zero,
  output logic                    busy
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
`ifdef VALU_SCALAR_FAST_EN
  localparam logic SCALAR_FAST = 1'b1;
`else
  localparam logic SCALAR_FAST = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                         state_q;
  logic [LANES-1:0][LANE_W-1:0]   a_q;
  logic [LANES-1:0][LANE_W-1:0]   b_q;
  logic [LANES-1:0][LANE_W-1:0]   res_q;
  logic [2:0]                     op_q;
  logic                           vec_q;
  logic [IDX_W-1:0]               lane_idx_q;
  logic [IDX_W-1:0]               lane_idx_d;
  logic                           lane_last;
  logic                           in_ready_q;
  logic                           busy_q;
  logic                           out_valid_q;
  logic                           lane_en_q;
  logic [LANE_W-1:0]              lane_a_q;
  logic [LANE_W-1:0]              lane_b_q;
  logic [2:0]                     lane_control_q;

  assign lane_idx_d = lane_idx_q + IDX_W'(1);
  assign lane_last  = (lane_idx_q == LAST_IDX) || (SCALAR_FAST && !vec_q);

  // Lane operands are registered one cycle ahead so they line up with lane_idx_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      a_q            <= '0;
      b_q            <= '0;
      res_q          <= '0;
      op_q           <= 3'b000;
      vec_q          <= 1'b0;
      lane_idx_q     <= '0;
      in_ready_q     <= 1'b1;
      busy_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      lane_en_q      <= 1'b0;
      lane_a_q       <= '0;
      lane_b_q       <= '0;
      lane_control_q <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q            <= in_a;
            b_q            <= in_b;
            op_q           <= in_alu_control;
            vec_q          <= in_vectorial;
            res_q          <= '0;
            lane_idx_q     <= '0;
            state_q        <= EXEC;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b1;
            lane_en_q      <= 1'b1;
            lane_a_q       <= in_a[LANE_W-1:0];
            lane_b_q       <= in_b[LANE_W-1:0];
            lane_control_q <= in_alu_control;
          end
        end
        EXEC: begin
          // Scalar requests only keep lane 0; upper slots stay zero whatever the ALU returns.
          res_q[lane_idx_q] <= (vec_q || (lane_idx_q == '0)) ? lane_result : '0;
          if (lane_last) begin
            lane_idx_q     <= '0;
            state_q        <= DONE;
            out_valid_q    <= 1'b1;
            lane_en_q      <= 1'b0;
            lane_a_q       <= '0;
            lane_b_q       <= '0;
            lane_control_q <= 3'b000;
          end else begin
            lane_idx_q <= lane_idx_d;
            lane_a_q   <= vec_q ? a_q[lane_idx_d] : '0;
            lane_b_q   <= vec_q ? b_q[lane_idx_d] : '0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          lane_en_q   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign lane_en      = lane_en_q;
  assign lane_a       = lane_a_q;
  assign lane_b       = lane_b_q;
  assign lane_control = lane_control_q;
  // Partial results are never visible: the result bus reads zero until DONE.
  assign out_result   = out_valid_q ? res_q : '0;
  assign out_zero     = (out_result == '0);

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Self-checking bench for vector_alu_sequencer: directed table, random ops against a lane-level model,
// backpressure, ignored requests and mid-operation reset.
module tb_vector_alu_sequencer;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;
`ifdef VALU_SCALAR_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    string          name;
    logic [127:0]   a;
    logic [127:0]   b;
    logic [2:0]     op;
    logic           vec;
    logic [127:0]   exp;
    logic           zero;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_a;
  logic [127:0] in_b;
  logic [2:0]   in_alu_control;
  logic         in_vectorial;
  logic         lane_en;
  logic [31:0]  lane_a;
  logic [31:0]  lane_b;
  logic [2:0]   lane_control;
  logic [31:0]  lane_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_result;
  logic         out_zero;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  vector_alu_sequencer #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_alu_control (in_alu_control),
    .in_vectorial   (in_vectorial),
    .lane_en        (lane_en),
    .lane_a         (lane_a),
    .lane_b         (lane_b),
    .lane_control   (lane_control),
    .lane_result    (lane_result),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_zero       (out_zero),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return $signed(a) >>> b[4:0];
    endcase
  endfunction

  // The lane ALU the sequencer drives lives in the bench.
  assign lane_result = alu(lane_control, lane_a, lane_b);

  function automatic logic [127:0] model(input logic [127:0] a, input logic [127:0] b,
                                         input logic [2:0] op, input logic vec);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++)
      if (vec || k == 0) r[k*32 +: 32] = alu(op, a[k*32 +: 32], b[k*32 +: 32]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic exec(input vec_t v, input int hold, input bit poke);
    logic [31:0]  la[$];
    logic [31:0]  lb[$];
    logic [31:0]  ea;
    logic [31:0]  eb;
    logic [127:0] held;
    int           lat;
    int           exp_lat;
    bit           ctl_bad;
    bit           stable_bad;
    exp_lat    = (v.vec || !FAST) ? LANES : 1;
    ctl_bad    = 1'b0;
    stable_bad = 1'b0;
    @(negedge clk);
    chk1({v.name, " in_ready idle"}, in_ready, 1'b1);
    in_a = v.a; in_b = v.b; in_alu_control = v.op; in_vectorial = v.vec; in_valid = 1'b1;
    @(posedge clk); #1;
    if (poke) begin
      in_a = ~v.a; in_b = ~v.b; in_alu_control = ~v.op; in_vectorial = ~v.vec;
    end else begin
      in_valid = 1'b0;
    end
    chk1({v.name, " accepted"}, busy, 1'b1);
    chk1({v.name, " in_ready low"}, in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (lane_en) begin
        la.push_back(lane_a);
        lb.push_back(lane_b);
        if (lane_control !== v.op) ctl_bad = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({v.name, " latency"}, 128'(lat), 128'(exp_lat));
    chk({v.name, " lane cycles"}, 128'(la.size()), 128'(exp_lat));
    chk1({v.name, " lane_control"}, ctl_bad, 1'b0);
    for (int k = 0; k < la.size() && k < LANES; k++) begin
      ea = (v.vec || k == 0) ? v.a[k*32 +: 32] : 32'h0;
      eb = (v.vec || k == 0) ? v.b[k*32 +: 32] : 32'h0;
      chk($sformatf("%s lane_a[%0d]", v.name, k), 128'(la[k]), 128'(ea));
      chk($sformatf("%s lane_b[%0d]", v.name, k), 128'(lb[k]), 128'(eb));
    end
    chk({v.name, " result"}, out_result, v.exp);
    chk1({v.name, " zero"}, out_zero, v.zero);
    held = out_result;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_result !== held || in_ready !== 1'b0) stable_bad = 1'b1;
    end
    if (hold > 0) chk1({v.name, " held stable"}, stable_bad, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk1({v.name, " out_valid drop"}, out_valid, 1'b0);
    chk1({v.name, " in_ready back"}, in_ready, 1'b1);
    if (poke) begin
      @(posedge clk); #1;
      chk1({v.name, " no queued req"}, busy, 1'b0);
    end
  endtask

  vec_t tbl[7];
  vec_t rv;
  bit   saw_valid;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"scalar_add", {32'h11111111, 32'h22222222, 32'h33333333, 32'h0000000A},
               {32'h44444444, 32'h55555555, 32'h66666666, 32'h00000014}, 3'b000, 1'b0,
               128'h1E, 1'b0};
    tbl[1] = '{"vec_sub", {32'd5, 32'd6, 32'd7, 32'd8}, {32'd1, 32'd2, 32'd3, 32'd4}, 3'b001, 1'b1,
               {4{32'h00000004}}, 1'b0};
    tbl[2] = '{"vec_xor_zero", {4{32'hAAAAAAAA}}, {4{32'hAAAAAAAA}}, 3'b100, 1'b1, 128'h0, 1'b1};
    tbl[3] = '{"vec_or_ones", {4{32'h55555555}}, {4{32'hAAAAAAAA}}, 3'b011, 1'b1,
               {4{32'hFFFFFFFF}}, 1'b0};
    tbl[4] = '{"vec_sra", {4{32'h80000000}}, {4{32'h00000002}}, 3'b111, 1'b1,
               {4{32'hE0000000}}, 1'b0};
    tbl[5] = '{"vec_sll_lanes", {4{32'h00000001}}, {32'd31, 32'd8, 32'd4, 32'd0}, 3'b101, 1'b1,
               {32'h80000000, 32'h00000100, 32'h00000010, 32'h00000001}, 1'b0};
    tbl[6] = '{"scalar_sub", {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'd5},
               {32'h0BADF00D, 32'h87654321, 32'h00000001, 32'd7}, 3'b001, 1'b0,
               128'hFFFFFFFE, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_alu_control = 3'b000;
    in_vectorial = 1'b0; out_ready = 1'b0;
    #12;
    chk1("reset in_ready", in_ready, 1'b1);
    chk1("reset busy", busy, 1'b0);
    chk1("reset out_valid", out_valid, 1'b0);
    chk("reset out_result", out_result, 128'h0);
    chk1("reset out_zero", out_zero, 1'b1);
    chk1("reset lane_en", lane_en, 1'b0);
    chk("reset lane_a", 128'(lane_a), 128'h0);
    chk("reset lane_b", 128'(lane_b), 128'h0);
    chk("reset lane_control", 128'(lane_control), 128'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 7; i++) exec(tbl[i], 0, 1'b0);

    // Backpressure for 10 cycles with a stray request held high through EXEC and DONE.
    exec(tbl[1], 10, 1'b1);
    exec(tbl[0], 3, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rv.name = $sformatf("rand%0d", i);
      rv.a    = {$urandom(), $urandom(), $urandom(), $urandom()};
      rv.b    = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) rv.b = rv.a;
      rv.op   = 3'($urandom_range(0, 7));
      rv.vec  = 1'($urandom_range(0, 1));
      rv.exp  = model(rv.a, rv.b, rv.op, rv.vec);
      rv.zero = (rv.exp == 128'h0);
      exec(rv, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset while lane 2 of a vector add is on the lane ALU.
    @(negedge clk);
    in_a = {32'd40, 32'd30, 32'd20, 32'd10}; in_b = {32'd4, 32'd3, 32'd2, 32'd1};
    in_alu_control = 3'b000; in_vectorial = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("abort lane2 operand", 128'(lane_a), 128'd30);
    rst_n = 1'b0;
    #1;
    chk1("abort busy", busy, 1'b0);
    chk1("abort in_ready", in_ready, 1'b1);
    chk1("abort lane_en", lane_en, 1'b0);
    chk("abort lane_a", 128'(lane_a), 128'h0);
    chk("abort out_result", out_result, 128'h0);
    chk1("abort out_zero", out_zero, 1'b1);
    saw_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk1("abort no out_valid", saw_valid, 1'b0);
    exec(tbl[4], 0, 1'b0);
    exec(tbl[0], 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
